// File: rtl/opb_register_bank_ppc2simulink_pkg.sv
// Shared types and constants for the OPB register bank: FSM states,
// control-word layout and OPB/user bit-order conversion.
package opb_regbank_pkg;

    localparam int BYTE_LANES      = 4;
    localparam int CTRL_COMMIT_BIT = 0;
    localparam int CTRL_DIRTY_BIT  = 0;
    localparam int CTRL_NREGS_LSB  = 24;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        WAIT = 2'd2
    } opb_state_e;

    // OPB numbers bit 0 as the MSB; the fabric side uses conventional [31:0].
    function automatic logic [31:0] opb_to_user(input logic [0:31] opb);
        logic [31:0] user;
        for (int i = 0; i < 32; i++) begin
            user[31-i] = opb[i];
        end
        return user;
    endfunction

    function automatic logic [0:31] user_to_opb(input logic [31:0] user);
        logic [0:31] opb;
        for (int i = 0; i < 32; i++) begin
            opb[i] = user[31-i];
        end
        return opb;
    endfunction

endpackage

// File: rtl/opb_register_bank_ppc2simulink_if.sv
// OPB slave-side bus bundle; the master modport is the bus (or a bench),
// the slave modport is the register bank.
interface opb_register_bank_ppc2simulink_if;

    logic [0:31] OPB_ABus;
    logic [0:3]  OPB_BE;
    logic [0:31] OPB_DBus;
    logic        OPB_RNW;
    logic        OPB_select;
    logic        OPB_seqAddr;

    logic [0:31] Sl_DBus;
    logic        Sl_errAck;
    logic        Sl_retry;
    logic        Sl_toutSup;
    logic        Sl_xferAck;

    modport master (
        output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
        input  Sl_DBus, Sl_errAck, Sl_retry, Sl_toutSup, Sl_xferAck
    );

    modport slave (
        input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
        output Sl_DBus, Sl_errAck, Sl_retry, Sl_toutSup, Sl_xferAck
    );

endinterface

// File: rtl/opb_register_bank_ppc2simulink_lane_reg.sv
// One 32-bit byte-enabled user register. With OPB_REGBANK_COMMIT_EN defined
// writes land in a shadow copy and reach the output only on commit.
module opb_regbank_lane_reg
    import opb_regbank_pkg::*;
#(
    parameter logic [31:0] RST_VAL = 32'h00000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [BYTE_LANES-1:0] be,
    input  logic [31:0]           wdata,
    input  logic                  commit,
    output logic [31:0]           sw_value,
    output logic [31:0]           out_value,
    output logic                  dirty,
    output logic                  update
);

    logic [31:0] lane_mask;
    logic [31:0] merged;
    logic        write_hit;

    always_comb begin
        lane_mask = '0;
        for (int b = 0; b < BYTE_LANES; b++) begin
            lane_mask[8*b +: 8] = {8{be[b]}};
        end
    end

    // An all-zero byte enable is still acknowledged but must not pulse update.
    assign merged    = (sw_value & ~lane_mask) | (wdata & lane_mask);
    assign write_hit = wr_en && (be != '0);

`ifdef OPB_REGBANK_COMMIT_EN
    logic [31:0] shadow_q;
    logic [31:0] out_q;
    logic        dirty_q;
    logic        update_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q <= RST_VAL;
            out_q    <= RST_VAL;
            dirty_q  <= 1'b0;
            update_q <= 1'b0;
        end else begin
            update_q <= 1'b0;
            if (write_hit) begin
                shadow_q <= merged;
                dirty_q  <= 1'b1;
            end
            if (commit) begin
                out_q    <= shadow_q;
                update_q <= dirty_q;
                dirty_q  <= 1'b0;
            end
        end
    end

    assign sw_value  = shadow_q;
    assign out_value = out_q;
    assign dirty     = dirty_q;
    assign update    = update_q;
`else
    logic [31:0] out_q;
    logic        update_q;
    logic        unused_commit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q    <= RST_VAL;
            update_q <= 1'b0;
        end else begin
            update_q <= write_hit;
            if (write_hit) begin
                out_q <= merged;
            end
        end
    end

    assign sw_value      = out_q;
    assign out_value     = out_q;
    assign dirty         = 1'b0;
    assign update        = update_q;
    assign unused_commit = commit;
`endif

endmodule

// File: rtl/opb_register_bank_ppc2simulink.sv
// OPB slave exposing N_REGS software-writable registers to fabric logic.
// Define OPB_REGBANK_COMMIT_EN for shadowed registers with atomic commit.
module opb_register_bank_ppc2simulink
    import opb_regbank_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR   = 32'h0108E700,
    parameter logic [31:0] C_HIGHADDR   = 32'h0108E7FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter int          N_REGS       = 4,
    parameter logic [31:0] RST_VAL      = 32'h00000000
) (
    input  logic                       OPB_Clk,
    input  logic                       OPB_Rst,
    opb_register_bank_ppc2simulink_if.slave bus,
    output logic [N_REGS*32-1:0]       user_data_out,
    output logic [N_REGS-1:0]          user_update
);

    localparam logic [7:0]  NREGS_BYTE = 8'(N_REGS);
    localparam logic [31:0] CTRL_IDX   = 32'(N_REGS);

    opb_state_e state_q;
    opb_state_e state_d;

    logic                    sel_q;
    logic                    rnw_q;
    logic [C_OPB_AWIDTH-1:0] addr_q;
    logic [C_OPB_DWIDTH-1:0] wdata_q;
    logic [BYTE_LANES-1:0]   be_q;

    logic        hit;
    logic [31:0] word_idx;
    logic        wr_cycle;
    logic        commit;
    logic [N_REGS-1:0] reg_wr;
    logic [N_REGS-1:0] reg_dirty;
    logic [31:0] sw_value [N_REGS];
    logic [31:0] rd_user;
    logic        unused_seq;

    // Address/data are frozen outside IDLE so the ACK cycle sees a stable copy.
    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            sel_q   <= 1'b0;
            rnw_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else begin
            sel_q <= bus.OPB_select;
            if (state_q == IDLE) begin
                addr_q  <= bus.OPB_ABus;
                rnw_q   <= bus.OPB_RNW;
                be_q    <= bus.OPB_BE;
                wdata_q <= opb_to_user(bus.OPB_DBus);
            end
        end
    end

    assign hit      = sel_q && (addr_q >= C_BASEADDR) && (addr_q <= C_HIGHADDR);
    assign word_idx = 32'((addr_q - C_BASEADDR) >> 2);

    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // WAIT holds until select drops so a long select earns only one ack.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (hit) state_d = ACK;
            ACK:     state_d = WAIT;
            WAIT:    if (!sel_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign wr_cycle = (state_q == ACK) && !rnw_q;
    assign commit   = wr_cycle && (word_idx == CTRL_IDX) && wdata_q[CTRL_COMMIT_BIT];

    always_comb begin
        reg_wr = '0;
        for (int k = 0; k < N_REGS; k++) begin
            reg_wr[k] = wr_cycle && (word_idx == 32'(k));
        end
    end

    for (genvar k = 0; k < N_REGS; k++) begin : g_lane
        opb_regbank_lane_reg #(
            .RST_VAL(RST_VAL)
        ) u_lane (
            .clk      (OPB_Clk),
            .rst      (OPB_Rst),
            .wr_en    (reg_wr[k]),
            .be       (be_q),
            .wdata    (wdata_q),
            .commit   (commit),
            .sw_value (sw_value[k]),
            .out_value(user_data_out[32*k +: 32]),
            .dirty    (reg_dirty[k]),
            .update   (user_update[k])
        );
    end

    // Out-of-range words fall through to zero.
    always_comb begin
        rd_user = '0;
        if (word_idx == CTRL_IDX) begin
            rd_user[CTRL_NREGS_LSB +: 8] = NREGS_BYTE;
            rd_user[CTRL_DIRTY_BIT]      = |reg_dirty;
        end
        for (int k = 0; k < N_REGS; k++) begin
            if (word_idx == 32'(k)) begin
                rd_user = sw_value[k];
            end
        end
    end

    assign bus.Sl_DBus    = ((state_q == ACK) && rnw_q) ? user_to_opb(rd_user) : '0;
    assign bus.Sl_xferAck = (state_q == ACK);
    assign bus.Sl_errAck  = 1'b0;
    assign bus.Sl_retry   = 1'b0;
    assign bus.Sl_toutSup = 1'b0;
    assign unused_seq     = bus.OPB_seqAddr;

endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
// Directed bench for the OPB register bank (N_REGS=4, default addresses);
// builds with or without OPB_REGBANK_COMMIT_EN.
module tb_opb_register_bank_ppc2simulink;
    import opb_regbank_pkg::*;

    localparam logic [31:0] BASE = 32'h0108E700;
`ifdef OPB_REGBANK_COMMIT_EN
    localparam bit COMMIT = 1'b1;
`else
    localparam bit COMMIT = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] user_data_out;
    logic [3:0]   user_update;

    int checks = 0;
    int failures = 0;
    int idle_dbus_bad = 0;
    int tie_bad = 0;

    opb_register_bank_ppc2simulink_if bus();

    opb_register_bank_ppc2simulink dut (
        .OPB_Clk      (clk),
        .OPB_Rst      (rst),
        .bus          (bus),
        .user_data_out(user_data_out),
        .user_update  (user_update)
    );

    always #5 clk = ~clk;

    // Bus-idle rules are watched continuously and judged in test_bus_idle.
    always @(negedge clk) begin
        if (!rst) begin
            if (!bus.Sl_xferAck && bus.Sl_DBus !== 32'h0) idle_dbus_bad++;
        end
        if (bus.Sl_errAck !== 1'b0 || bus.Sl_retry !== 1'b0 || bus.Sl_toutSup !== 1'b0) tie_bad++;
    end

    task automatic opb_xfer(input bit rnw, input logic [31:0] addr, input logic [3:0] be,
                            input logic [31:0] wdata, output logic [31:0] rdata,
                            output bit got_ack, output int ack_cyc, output logic [127:0] out_at_ack);
        got_ack = 1'b0;
        rdata = '0;
        ack_cyc = -1;
        out_at_ack = '0;
        @(posedge clk); #1;
        bus.OPB_select = 1'b1;
        bus.OPB_RNW = rnw;
        bus.OPB_ABus = addr;
        bus.OPB_BE = be;
        bus.OPB_DBus = wdata;
        for (int i = 0; i < 10 && !got_ack; i++) begin
            @(negedge clk);
            if (bus.Sl_xferAck === 1'b1) begin
                got_ack = 1'b1;
                ack_cyc = i;
                rdata = bus.Sl_DBus;
                out_at_ack = user_data_out;
            end
        end
        @(posedge clk); #1;
        bus.OPB_select = 1'b0;
        bus.OPB_RNW = 1'b0;
        bus.OPB_DBus = '0;
        bus.OPB_BE = '0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (bus.Sl_xferAck !== 1'b0) begin failures++; $display("[TB] FAIL reset_ack: got %b expected 0", bus.Sl_xferAck); end
        checks++; if (bus.Sl_DBus !== 32'h0) begin failures++; $display("[TB] FAIL reset_dbus: got %h expected 0", bus.Sl_DBus); end
        checks++; if (user_update !== 4'b0) begin failures++; $display("[TB] FAIL reset_update: got %b expected 0000", user_update); end
        checks++; if (user_data_out !== 128'h0) begin failures++; $display("[TB] FAIL reset_out: got %h expected 0", user_data_out); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_write_read();
        logic [31:0] rd; bit ok; int cyc; logic [127:0] pre; logic [127:0] exp;
        exp = COMMIT ? 128'h0 : {32'h0, 32'h0, 32'hDEADBEEF, 32'h0};
        opb_xfer(1'b0, 32'h0108E704, 4'b1111, 32'hDEADBEEF, rd, ok, cyc, pre);
        checks++; if (!ok) begin failures++; $display("[TB] FAIL wr_ack: no ack, expected one"); end
        checks++; if (cyc != 2) begin failures++; $display("[TB] FAIL wr_latency: ack in cycle %0d expected 2", cyc); end
        checks++; if (pre[63:32] !== 32'h0) begin failures++; $display("[TB] FAIL wr_early: reg1 %h during ack expected 0", pre[63:32]); end
        @(negedge clk);
        checks++; if (bus.Sl_xferAck !== 1'b0) begin failures++; $display("[TB] FAIL wr_ack_len: ack %b after one cycle expected 0", bus.Sl_xferAck); end
        checks++; if (user_data_out !== exp) begin failures++; $display("[TB] FAIL wr_out: got %h expected %h", user_data_out, exp); end
        checks++; if (user_update !== (COMMIT ? 4'b0000 : 4'b0010)) begin failures++; $display("[TB] FAIL wr_update: got %b", user_update); end
        @(negedge clk);
        checks++; if (user_update !== 4'b0) begin failures++; $display("[TB] FAIL wr_pulse_len: got %b expected 0000", user_update); end
        opb_xfer(1'b1, 32'h0108E704, 4'b1111, 32'h0, rd, ok, cyc, pre);
        checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("[TB] FAIL rd_reg1: got %h expected deadbeef", rd); end
    endtask

    task automatic test_partial();
        logic [31:0] rd; bit ok; int cyc; logic [127:0] pre;
        opb_xfer(1'b0, 32'h0108E700, 4'b1111, 32'h11223344, rd, ok, cyc, pre);
        opb_xfer(1'b0, 32'h0108E700, 4'b0001, 32'h000000AA, rd, ok, cyc, pre);
        @(negedge clk);
        checks++; if (user_update !== (COMMIT ? 4'b0000 : 4'b0001)) begin failures++; $display("[TB] FAIL part_update: got %b", user_update); end
        opb_xfer(1'b1, 32'h0108E700, 4'b1111, 32'h0, rd, ok, cyc, pre);
        checks++; if (rd !== 32'h112233AA) begin failures++; $display("[TB] FAIL part_lane3: got %h expected 112233aa", rd); end
        opb_xfer(1'b0, 32'h0108E700, 4'b1000, 32'hFF000000, rd, ok, cyc, pre);
        opb_xfer(1'b0, 32'h0108E700, 4'b0000, 32'h12345678, rd, ok, cyc, pre);
        checks++; if (!ok) begin failures++; $display("[TB] FAIL be0_ack: no ack, expected one"); end
        @(negedge clk);
        checks++; if (user_update !== 4'b0) begin failures++; $display("[TB] FAIL be0_update: got %b expected 0000", user_update); end
        opb_xfer(1'b1, 32'h0108E700, 4'b1111, 32'h0, rd, ok, cyc, pre);
        checks++; if (rd !== 32'hFF2233AA) begin failures++; $display("[TB] FAIL part_lane0: got %h expected ff2233aa", rd); end
        checks++; if (user_data_out[31:0] !== (COMMIT ? 32'h0 : 32'hFF2233AA)) begin failures++; $display("[TB] FAIL part_out: got %h", user_data_out[31:0]); end
    endtask

    task automatic test_control_oob();
        logic [31:0] rd; bit ok; int cyc; logic [127:0] pre; logic [127:0] exp;
        exp = COMMIT ? 128'h0 : {32'h0, 32'h0, 32'hDEADBEEF, 32'hFF2233AA};
        opb_xfer(1'b1, 32'h0108E710, 4'b1111, 32'h0, rd, ok, cyc, pre);
        checks++; if (rd !== (COMMIT ? 32'h04000001 : 32'h04000000)) begin failures++; $display("[TB] FAIL ctrl_read: got %h", rd); end
        opb_xfer(1'b0, 32'h0108E710, 4'b1111, 32'hFFFFFFFE, rd, ok, cyc, pre);
        @(negedge clk);
        checks++; if (user_update !== 4'b0) begin failures++; $display("[TB] FAIL ctrl_wr_update: got %b expected 0000", user_update); end
        checks++; if (user_data_out !== exp) begin failures++; $display("[TB] FAIL ctrl_wr_out: got %h expected %h", user_data_out, exp); end
        opb_xfer(1'b0, 32'h0108E7F0, 4'b1111, 32'hFFFFFFFF, rd, ok, cyc, pre);
        checks++; if (!ok) begin failures++; $display("[TB] FAIL oob_wr_ack: no ack, expected one"); end
        @(negedge clk);
        checks++; if (user_update !== 4'b0) begin failures++; $display("[TB] FAIL oob_wr_update: got %b expected 0000", user_update); end
        checks++; if (user_data_out !== exp) begin failures++; $display("[TB] FAIL oob_wr_out: got %h expected %h", user_data_out, exp); end
        opb_xfer(1'b1, 32'h0108E7F0, 4'b1111, 32'h0, rd, ok, cyc, pre);
        checks++; if (!ok || rd !== 32'h0) begin failures++; $display("[TB] FAIL oob_read: ack %0b data %h expected 1 / 0", ok, rd); end
        opb_xfer(1'b1, 32'h0108E714, 4'b1111, 32'h0, rd, ok, cyc, pre);
        checks++; if (rd !== 32'h0) begin failures++; $display("[TB] FAIL idx5_read: got %h expected 0", rd); end
        opb_xfer(1'b1, 32'h0108E707, 4'b1111, 32'h0, rd, ok, cyc, pre);
        checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("[TB] FAIL lowbits_read: got %h expected deadbeef", rd); end
    endtask

    task automatic test_held_select();
        int acks = 0; logic [31:0] rd = '0;
        @(posedge clk); #1;
        bus.OPB_select = 1'b1; bus.OPB_RNW = 1'b1; bus.OPB_ABus = 32'h0108E704; bus.OPB_BE = 4'b1111;
        repeat (6) begin
            @(negedge clk);
            if (bus.Sl_xferAck === 1'b1) begin acks++; rd = bus.Sl_DBus; end
        end
        @(posedge clk); #1;
        bus.OPB_select = 1'b0; bus.OPB_RNW = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus.Sl_xferAck === 1'b1) acks++;
        end
        checks++; if (acks != 1) begin failures++; $display("[TB] FAIL held_acks: got %0d expected 1", acks); end
        checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("[TB] FAIL held_data: got %h expected deadbeef", rd); end
    endtask

`ifdef OPB_REGBANK_COMMIT_EN
    task automatic test_commit();
        logic [31:0] rd; bit ok; int cyc; logic [127:0] pre;
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        opb_xfer(1'b0, 32'h0108E704, 4'b1111, 32'h00000005, rd, ok, cyc, pre);
        opb_xfer(1'b0, 32'h0108E70C, 4'b1111, 32'h00000007, rd, ok, cyc, pre);
        @(negedge clk);
        checks++; if (user_data_out !== 128'h0) begin failures++; $display("[TB] FAIL shadow_hold: got %h expected 0", user_data_out); end
        checks++; if (user_update !== 4'b0) begin failures++; $display("[TB] FAIL shadow_update: got %b expected 0000", user_update); end
        opb_xfer(1'b1, 32'h0108E710, 4'b1111, 32'h0, rd, ok, cyc, pre);
        checks++; if (rd !== 32'h04000001) begin failures++; $display("[TB] FAIL dirty_read: got %h expected 04000001", rd); end
        opb_xfer(1'b0, 32'h0108E710, 4'b1111, 32'h00000001, rd, ok, cyc, pre);
        checks++; if (pre !== 128'h0) begin failures++; $display("[TB] FAIL commit_early: got %h expected 0", pre); end
        @(negedge clk);
        checks++; if (user_data_out !== {32'h7, 32'h0, 32'h5, 32'h0}) begin failures++; $display("[TB] FAIL commit_out: got %h", user_data_out); end
        checks++; if (user_update !== 4'b1010) begin failures++; $display("[TB] FAIL commit_update: got %b expected 1010", user_update); end
        @(negedge clk);
        checks++; if (user_update !== 4'b0) begin failures++; $display("[TB] FAIL commit_pulse_len: got %b expected 0000", user_update); end
        opb_xfer(1'b1, 32'h0108E710, 4'b1111, 32'h0, rd, ok, cyc, pre);
        checks++; if (rd !== 32'h04000000) begin failures++; $display("[TB] FAIL clean_read: got %h expected 04000000", rd); end
    endtask
`endif

    task automatic test_reset_mid_ack();
        logic [31:0] rd; bit ok; int cyc; logic [127:0] pre; bit seen = 1'b0;
        opb_xfer(1'b0, 32'h0108E708, 4'b1111, 32'hCAFEF00D, rd, ok, cyc, pre);
        @(negedge clk);
        checks++; if (user_data_out[95:64] !== (COMMIT ? 32'h0 : 32'hCAFEF00D)) begin failures++; $display("[TB] FAIL pre_rst_out: got %h", user_data_out[95:64]); end
        @(posedge clk); #1;
        bus.OPB_select = 1'b1; bus.OPB_RNW = 1'b0; bus.OPB_ABus = 32'h0108E70C;
        bus.OPB_BE = 4'b1111; bus.OPB_DBus = 32'h12345678;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (bus.Sl_xferAck === 1'b1) seen = 1'b1;
        end
        checks++; if (!seen) begin failures++; $display("[TB] FAIL mid_ack_seen: no ack, expected one"); end
        rst = 1'b1;
        #1;
        checks++; if (bus.Sl_xferAck !== 1'b0) begin failures++; $display("[TB] FAIL mid_rst_ack: got %b expected 0", bus.Sl_xferAck); end
        checks++; if (bus.Sl_DBus !== 32'h0) begin failures++; $display("[TB] FAIL mid_rst_dbus: got %h expected 0", bus.Sl_DBus); end
        checks++; if (user_data_out !== 128'h0) begin failures++; $display("[TB] FAIL mid_rst_out: got %h expected 0", user_data_out); end
        checks++; if (dut.state_q !== IDLE) begin failures++; $display("[TB] FAIL mid_rst_state: got %0d expected IDLE", dut.state_q); end
        bus.OPB_select = 1'b0; bus.OPB_DBus = '0; bus.OPB_BE = '0;
        @(posedge clk); #1; rst = 1'b0;
        opb_xfer(1'b1, 32'h0108E70C, 4'b1111, 32'h0, rd, ok, cyc, pre);
        checks++; if (!ok || rd !== 32'h0) begin failures++; $display("[TB] FAIL post_rst_reg3: ack %0b data %h expected 1 / 0", ok, rd); end
        opb_xfer(1'b1, 32'h0108E708, 4'b1111, 32'h0, rd, ok, cyc, pre);
        checks++; if (rd !== 32'h0) begin failures++; $display("[TB] FAIL post_rst_reg2: got %h expected 0", rd); end
    endtask

    task automatic test_bus_idle();
        logic [31:0] model [4] = '{default: 32'h0};
        bit mdirty = 1'b0;
        logic [31:0] rd, wdata, exp; bit ok; int cyc; logic [127:0] pre;
        int idx; bit rnw; logic [3:0] be;
        for (int n = 0; n < 1000; n++) begin
            idx = int'($urandom_range(0, 6));
            rnw = 1'($urandom_range(0, 1));
            be = 4'($urandom_range(0, 15));
            wdata = $urandom;
            if (idx == 4) wdata[0] = 1'b0;
            repeat ($urandom_range(0, 2)) @(posedge clk);
            opb_xfer(rnw, BASE + 32'(idx * 4) + 32'($urandom_range(0, 3)), be, wdata, rd, ok, cyc, pre);
            checks++; if (!ok) begin failures++; $display("[TB] FAIL rand_ack: transfer %0d no ack", n); end
            if (rnw) begin
                if (idx < 4) exp = model[idx];
                else if (idx == 4) exp = 32'h04000000 | {31'h0, COMMIT & mdirty};
                else exp = 32'h0;
                checks++; if (rd !== exp) begin failures++; $display("[TB] FAIL rand_read: idx %0d got %h expected %h", idx, rd, exp); end
            end else if (idx < 4) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) model[idx][8*b +: 8] = wdata[8*b +: 8];
                end
                if (be != 4'b0) mdirty = 1'b1;
            end
        end
        checks++; if (idle_dbus_bad != 0) begin failures++; $display("[TB] FAIL idle_dbus: %0d nonzero idle cycles, expected 0", idle_dbus_bad); end
        checks++; if (tie_bad != 0) begin failures++; $display("[TB] FAIL tied_outputs: %0d bad cycles, expected 0", tie_bad); end
    endtask

    initial begin
        bus.OPB_ABus = '0; bus.OPB_BE = '0; bus.OPB_DBus = '0;
        bus.OPB_RNW = 1'b0; bus.OPB_select = 1'b0; bus.OPB_seqAddr = 1'b0;
        test_reset();
        test_write_read();
        test_partial();
        test_control_oob();
        test_held_select();
`ifdef OPB_REGBANK_COMMIT_EN
        test_commit();
`endif
        test_reset_mid_ack();
        test_bus_idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/opb_register_bank_ppc2simulink.md
Name: opb_register_bank_ppc2simulink

Overview:
- Parametrised successor to the single-register PPC-to-Simulink OPB slave.
- Exposes N_REGS software-writable 32-bit registers to fabric logic behind one OPB address window, with byte-enable writes, readback and per-register update strobes.
- Optional double-buffered (shadow/commit) mode updates all outputs atomically.
- Sits on the PPC OPB bus; outputs feed DSP gain, quantiser and control inputs in the same clock domain.

Parameters:
- C_BASEADDR, 32'h0108E700, first byte address of the window.
- C_HIGHADDR, 32'h0108E7FF, last byte address; must satisfy HIGHADDR-BASEADDR+1 >= 4*(N_REGS+1).
- C_OPB_AWIDTH, 32, OPB address width.
- C_OPB_DWIDTH, 32, OPB data width; only 32 is supported.
- N_REGS, 4, number of user registers, 1..64.
- RST_VAL, 32'h00000000, reset value of every user and shadow register.

Ports:
- OPB_Clk  in  1  sole clock; bus and user side both run on it.
- OPB_Rst  in  1  reset, asynchronous, active-high.
- OPB_ABus  in  [0:31]  byte address.
- OPB_BE  in  [0:3]  byte enables; BE[0] selects DBus[0:7].
- OPB_DBus  in  [0:31]  write data; bit 0 is the MSB.
- OPB_RNW  in  1  1 = read, 0 = write.
- OPB_select  in  1  master transfer valid.
- OPB_seqAddr  in  1  ignored.
- Sl_DBus  out  [0:31]  read data; zero whenever Sl_xferAck=0.
- Sl_errAck  out  1  tied 0.
- Sl_retry  out  1  tied 0.
- Sl_toutSup  out  1  tied 0.
- Sl_xferAck  out  1  one-cycle transfer acknowledge.
- user_data_out  out  [N_REGS*32-1:0]  register k occupies bits [32k+31:32k]; OPB bit 0 maps to bit 31.
- user_update  out  [N_REGS-1:0]  one-cycle pulse when register k's output changes source.

Behaviour:
- Hit condition: OPB_select=1 and C_BASEADDR <= OPB_ABus <= C_HIGHADDR. Word index idx = (OPB_ABus - C_BASEADDR) >> 2; ABus[30:31] are ignored.
- FSM states:
  - IDLE: on hit, go to ACK.
  - ACK: Sl_xferAck=1 for exactly this cycle; the write is performed or read data is driven. Go to WAIT.
  - WAIT: stay while OPB_select=1; return to IDLE when it drops. This guarantees one ack per select assertion.
- Latency: select sampled at edge T, xferAck high during T+1 to T+2, user_data_out updated at edge T+2 together with user_update[k]=1 for one cycle.
- Writes with idx < N_REGS: only lanes with BE=1 are written. Lane 0 = bits [31:24] ... lane 3 = bits [7:0]. user_update[k] pulses even if the data is unchanged. BE=0000 is acknowledged, no data change, no pulse.
- Reads with idx < N_REGS: Sl_DBus = current value of the register as written by software (the shadow in commit mode), with bit order reversed to OPB order.
- idx = N_REGS is the control word: read returns {N_REGS[7:0], 24'h0} in OPB bits [0:7] / [8:31]. A write is a no-op without commit mode.
- idx > N_REGS: acknowledged, reads zero, writes ignored. No error is signalled.
- Sl_DBus is zero-masked outside ACK, as OPB OR-bus rules require.
- Reset (any time, including mid-transfer): FSM goes to IDLE. Sl_xferAck=0, Sl_DBus=0, user_update=0, all registers = RST_VAL. Error outputs are always 0.
- A deassert of select during ACK still completes the transfer; the FSM then passes through WAIT to IDLE.

Optional Feature:
- OPB_REGBANK_COMMIT_EN defined:
  - Writes with idx < N_REGS go to shadow registers only; outputs hold.
  - A write to idx = N_REGS with DBus[31]=1 (control bit 0) copies all shadows to the outputs at the same edge as a normal write. user_update pulses for every register whose shadow was written since the last commit; the dirty flags then clear.
  - Control read returns bit 31 = any-dirty flag.
- OPB_REGBANK_COMMIT_EN undefined: writes go straight to the outputs; no shadow storage is instantiated.

Decomposition:
- Package opb_regbank_pkg holds:
  - FSM state enum (IDLE/ACK/WAIT).
  - BYTE_LANES=4.
  - Control-word bit positions.
  - A function for OPB-to-user bit reversal.
- One natural sub-module: opb_regbank_lane_reg, a single 32-bit byte-enabled register with optional shadow. It is generated N_REGS times.

Test Plan:
- Reset check: assert OPB_Rst mid-ACK -> Sl_xferAck=0 immediately; user_data_out = all RST_VAL; FSM back in IDLE.
- Full write/read: N_REGS=4, write 0xDEADBEEF, BE=1111, to 0x0108E704 -> xferAck one cycle; user_data_out[63:32]=0xDEADBEEF; user_update=0010; readback returns 0xDEADBEEF.
- Partial write: write 0x000000AA, BE=0001, to 0x0108E700 over reg0=0x11223344 -> reg0=0x112233AA.
- Control and out-of-range: read 0x0108E710 -> 0x04000000; write to 0x0108E7F0 acked, no output change; select held high for 5 cycles -> exactly one xferAck.
- Commit mode (macro defined): write reg1=0x5 and reg3=0x7 -> outputs unchanged; write 0x1 to 0x0108E710 -> both outputs update on the same edge, user_update=1010.
- Bus idle: Sl_DBus=0 whenever Sl_xferAck=0, across 1000 random transfers; Sl_errAck, Sl_retry and Sl_toutSup never 1.
